// File: rtl/fpu_exp_align_seq.sv
// Exponent-alignment sequencer for the FPU add/sub path: orders two operands by
// exponent and right-shifts the smaller significand SHIFT_STEP bits per cycle.
// Optional: define FPU_ALIGN_STICKY_EN to OR shifted-out bits into the sticky bit.
module fpu_exp_align_seq #(
  parameter int unsigned SIZE_EXP   = 8,
  parameter int unsigned SIZE_MAN   = 23,
  parameter int unsigned SHIFT_STEP = 4
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_valid,
  output logic                         o_ready,
  input  logic [SIZE_EXP+SIZE_MAN:0]   i_data_a,
  input  logic [SIZE_EXP+SIZE_MAN:0]   i_data_b,
  output logic                         o_valid,
  input  logic                         i_ready,
  output logic                         o_swap,
  output logic                         o_sign_big,
  output logic                         o_sign_small,
  output logic [SIZE_EXP-1:0]          o_exp_max,
  output logic [SIZE_MAN+3:0]          o_man_big,
  output logic [SIZE_MAN+3:0]          o_man_small,
  output logic                         o_busy
);

  localparam int unsigned W  = SIZE_MAN + 4;
  localparam int unsigned DW = 1 + SIZE_EXP + SIZE_MAN;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_e;

  state_e                state_q, state_d;
  logic                  ready_q, ready_d;
  logic                  valid_q, valid_d;
  logic                  busy_q, busy_d;
  logic                  swap_q, swap_d;
  logic                  sign_big_q, sign_big_d;
  logic                  sign_small_q, sign_small_d;
  logic                  clamp_q, clamp_d;
  logic [SIZE_EXP-1:0]   exp_max_q, exp_max_d;
  logic [SIZE_EXP-1:0]   rem_q, rem_d;
  logic [W-1:0]          man_big_q, man_big_d;
  logic [W-1:0]          man_small_q, man_small_d;

  // Operand decode: a zero exponent field means denormal (exp 1, hidden 0)
  logic [SIZE_EXP-1:0]   exp_a_f, exp_b_f, eff_a, eff_b, diff_c;
  logic                  hid_a, hid_b, swap_c;
  logic [W-1:0]          man_a, man_b;

  always_comb begin
    exp_a_f = i_data_a[DW-2:SIZE_MAN];
    exp_b_f = i_data_b[DW-2:SIZE_MAN];
    hid_a   = |exp_a_f;
    hid_b   = |exp_b_f;
    eff_a   = hid_a ? exp_a_f : SIZE_EXP'(1);
    eff_b   = hid_b ? exp_b_f : SIZE_EXP'(1);
    man_a   = {hid_a, i_data_a[SIZE_MAN-1:0], 3'b000};
    man_b   = {hid_b, i_data_b[SIZE_MAN-1:0], 3'b000};
    swap_c  = eff_a < eff_b;
    diff_c  = swap_c ? (eff_b - eff_a) : (eff_a - eff_b);
  end

  // One shift step of k = min(SHIFT_STEP, remaining) bits
  logic [SIZE_EXP-1:0]   k_c;
  logic [W-1:0]          step_man_c, clamp_man_c;

`ifdef FPU_ALIGN_STICKY_EN
  logic                  lost_c;
  always_comb begin
    k_c    = (rem_q < SIZE_EXP'(SHIFT_STEP)) ? rem_q : SIZE_EXP'(SHIFT_STEP);
    lost_c = 1'b0;
    for (int unsigned i = 0; i < W; i++) begin
      if (i < 32'(k_c)) lost_c = lost_c | man_small_q[i];
    end
    step_man_c  = (man_small_q >> k_c) | {{(W-1){1'b0}}, lost_c};
    clamp_man_c = {{(W-1){1'b0}}, |man_small_q};
  end
`else
  always_comb begin
    k_c         = (rem_q < SIZE_EXP'(SHIFT_STEP)) ? rem_q : SIZE_EXP'(SHIFT_STEP);
    step_man_c  = man_small_q >> k_c;
    clamp_man_c = '0;
  end
`endif

  // Next-state and registered-output logic
  always_comb begin
    state_d      = state_q;
    ready_d      = ready_q;
    valid_d      = valid_q;
    busy_d       = busy_q;
    swap_d       = swap_q;
    sign_big_d   = sign_big_q;
    sign_small_d = sign_small_q;
    clamp_d      = clamp_q;
    exp_max_d    = exp_max_q;
    rem_d        = rem_q;
    man_big_d    = man_big_q;
    man_small_d  = man_small_q;
    case (state_q)
      S_IDLE: begin
        if (i_valid && ready_q) begin
          ready_d      = 1'b0;
          busy_d       = 1'b1;
          valid_d      = 1'b0;
          swap_d       = swap_c;
          sign_big_d   = swap_c ? i_data_b[DW-1] : i_data_a[DW-1];
          sign_small_d = swap_c ? i_data_a[DW-1] : i_data_b[DW-1];
          exp_max_d    = swap_c ? eff_b : eff_a;
          man_big_d    = swap_c ? man_b : man_a;
          man_small_d  = swap_c ? man_a : man_b;
          rem_d        = diff_c;
          clamp_d      = 32'(diff_c) >= W;
          state_d      = (diff_c == '0) ? S_DONE : S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (clamp_q) begin
          man_small_d = clamp_man_c;
          rem_d       = '0;
          clamp_d     = 1'b0;
          state_d     = S_DONE;
        end else begin
          man_small_d = step_man_c;
          rem_d       = rem_q - k_c;
          if (rem_q == k_c) state_d = S_DONE;
        end
      end
      S_DONE: begin
        // valid rises one cycle after entering DONE to give the fixed latency
        if (valid_q && i_ready) begin
          valid_d = 1'b0;
          ready_d = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          valid_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= S_IDLE;
      ready_q      <= 1'b1;
      valid_q      <= 1'b0;
      busy_q       <= 1'b0;
      swap_q       <= 1'b0;
      sign_big_q   <= 1'b0;
      sign_small_q <= 1'b0;
      clamp_q      <= 1'b0;
      exp_max_q    <= '0;
      rem_q        <= '0;
      man_big_q    <= '0;
      man_small_q  <= '0;
    end else begin
      state_q      <= state_d;
      ready_q      <= ready_d;
      valid_q      <= valid_d;
      busy_q       <= busy_d;
      swap_q       <= swap_d;
      sign_big_q   <= sign_big_d;
      sign_small_q <= sign_small_d;
      clamp_q      <= clamp_d;
      exp_max_q    <= exp_max_d;
      rem_q        <= rem_d;
      man_big_q    <= man_big_d;
      man_small_q  <= man_small_d;
    end
  end

  assign o_ready      = ready_q;
  assign o_valid      = valid_q;
  assign o_busy       = busy_q;
  assign o_swap       = swap_q;
  assign o_sign_big   = sign_big_q;
  assign o_sign_small = sign_small_q;
  assign o_exp_max    = exp_max_q;
  assign o_man_big    = man_big_q;
  assign o_man_small  = man_small_q;

endmodule

// File: tb/tb_fpu_exp_align_seq.sv
// Directed bench for fpu_exp_align_seq: latency, ordering, alignment, sticky,
// clamp, backpressure and mid-operation reset.
module tb_fpu_exp_align_seq;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_valid;
  logic        o_ready;
  logic [31:0] i_data_a;
  logic [31:0] i_data_b;
  logic        o_valid;
  logic        i_ready;
  logic        o_swap;
  logic        o_sign_big;
  logic        o_sign_small;
  logic [7:0]  o_exp_max;
  logic [26:0] o_man_big;
  logic [26:0] o_man_small;
  logic        o_busy;

  int total = 0;
  int bad   = 0;

  fpu_exp_align_seq dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_data_a    (i_data_a),
    .i_data_b    (i_data_b),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_swap      (o_swap),
    .o_sign_big  (o_sign_big),
    .o_sign_small(o_sign_small),
    .o_exp_max   (o_exp_max),
    .o_man_big   (o_man_big),
    .o_man_small (o_man_small),
    .o_busy      (o_busy)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Issue one pair, measure latency, check the result, optionally stall, then hand off
  task automatic run_vec(input string name, input logic [31:0] a, input logic [31:0] b,
                         input int lat, input logic sw, input logic sb, input logic ss,
                         input logic [7:0] ex, input logic [26:0] mb, input logic [26:0] ms,
                         input int hold);
    int cyc;
    cyc = 0;
    while (!o_ready && cyc < 50) begin
      @(posedge i_clk); #1; cyc++;
    end
    i_valid  = 1'b1;
    i_data_a = a;
    i_data_b = b;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    chk({name, "/ready_low"}, 64'(o_ready), 64'd0);
    cyc = 0;
    while (!o_valid && cyc < 50) begin
      @(posedge i_clk); #1; cyc++;
    end
    chk({name, "/latency"}, 64'(cyc), 64'(lat));
    chk({name, "/swap"}, 64'(o_swap), 64'(sw));
    chk({name, "/sign_big"}, 64'(o_sign_big), 64'(sb));
    chk({name, "/sign_small"}, 64'(o_sign_small), 64'(ss));
    chk({name, "/exp_max"}, 64'(o_exp_max), 64'(ex));
    chk({name, "/man_big"}, 64'(o_man_big), 64'(mb));
    chk({name, "/man_small"}, 64'(o_man_small), 64'(ms));
    for (int h = 0; h < hold; h++) begin
      i_valid  = 1'b1;
      i_data_a = 32'h3F80_0000;
      i_data_b = 32'h4000_0000;
      @(posedge i_clk); #1;
      chk({name, "/hold_valid"}, 64'(o_valid), 64'd1);
      chk({name, "/hold_ready"}, 64'(o_ready), 64'd0);
      chk({name, "/hold_small"}, 64'(o_man_small), 64'(ms));
      chk({name, "/hold_exp"}, 64'(o_exp_max), 64'(ex));
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    @(posedge i_clk); #1;
    i_ready = 1'b0;
    chk({name, "/post_valid"}, 64'(o_valid), 64'd0);
    chk({name, "/post_ready"}, 64'(o_ready), 64'd1);
    chk({name, "/post_busy"}, 64'(o_busy), 64'd0);
  endtask

  initial begin
    logic [26:0] exp_sticky9, exp_clamp;
`ifdef FPU_ALIGN_STICKY_EN
    exp_sticky9 = 27'h002_0001;
    exp_clamp   = 27'h000_0001;
`else
    exp_sticky9 = 27'h002_0000;
    exp_clamp   = 27'h000_0000;
`endif
    i_rst_n  = 1'b0;
    i_valid  = 1'b0;
    i_ready  = 1'b0;
    i_data_a = '0;
    i_data_b = '0;
    #12;
    chk("reset/valid", 64'(o_valid), 64'd0);
    chk("reset/busy", 64'(o_busy), 64'd0);
    chk("reset/man_small", 64'(o_man_small), 64'd0);
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;
    chk("reset/ready", 64'(o_ready), 64'd1);

    run_vec("eq_exp", 32'h4040_0000, 32'h4000_0000, 1, 1'b0, 1'b0, 1'b0,
            8'd128, 27'h600_0000, 27'h400_0000, 0);
    run_vec("diff1_swap", 32'h3F80_0000, 32'h4000_0000, 2, 1'b1, 1'b0, 1'b0,
            8'd128, 27'h400_0000, 27'h200_0000, 0);
    run_vec("diff9", 32'h3F80_0001, 32'h4400_0000, 4, 1'b1, 1'b0, 1'b0,
            8'd136, 27'h400_0000, exp_sticky9, 0);
    run_vec("clamp32", 32'h3F80_0000, 32'h4F80_0000, 2, 1'b1, 1'b0, 1'b0,
            8'd159, 27'h400_0000, exp_clamp, 0);
    run_vec("diff26", 32'h4C80_0000, 32'h3F80_0000, 8, 1'b0, 1'b0, 1'b0,
            8'd153, 27'h400_0000, 27'h000_0001, 0);
    run_vec("denorm_clamp", 32'hC000_0000, 32'h0000_0001, 2, 1'b0, 1'b1, 1'b0,
            8'd128, 27'h400_0000, exp_clamp, 0);
    run_vec("backpressure", 32'h4040_0000, 32'h4000_0000, 1, 1'b0, 1'b0, 1'b0,
            8'd128, 27'h600_0000, 27'h400_0000, 5);

    // Reset while the diff-9 pair is still shifting
    i_valid  = 1'b1;
    i_data_a = 32'h3F80_0001;
    i_data_b = 32'h4400_0000;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    @(posedge i_clk); #1;
    chk("midrst/busy_before", 64'(o_busy), 64'd1);
    i_rst_n = 1'b0;
    #1;
    chk("midrst/valid", 64'(o_valid), 64'd0);
    chk("midrst/busy", 64'(o_busy), 64'd0);
    chk("midrst/man_small", 64'(o_man_small), 64'd0);
    chk("midrst/man_big", 64'(o_man_big), 64'd0);
    chk("midrst/exp_max", 64'(o_exp_max), 64'd0);
    chk("midrst/swap", 64'(o_swap), 64'd0);
    #3;
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;
    chk("midrst/ready", 64'(o_ready), 64'd1);
    chk("midrst/valid_after", 64'(o_valid), 64'd0);
    run_vec("after_rst", 32'h3F80_0000, 32'h4000_0000, 2, 1'b1, 1'b0, 1'b0,
            8'd128, 27'h400_0000, 27'h200_0000, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
